hazard_glitch_monitor: RTL and testbench

Sequential monitor on the output of a hazard-prone combinational net, such as the SOP mux-style circuits in this codebase. It oversamples a single-bit signal with the system clock and classifies every excursion from the current stable level:
- a short excursion is a glitch: a static-1 or static-0 hazard pulse;
- a long excursion is a legitimate transition.
It produces a deglitched copy of the signal, a per-event strobe with type and width, and a saturating event counter. The verification team uses it as the receiving end of the hazard demonstration circuits, to prove that a consensus-term correction removes the glitch.

---
 rtl/hazard_glitch_monitor_pkg.sv | 19 +
 rtl/hazard_glitch_monitor_sat_counter.sv | 51 +++++
 rtl/hazard_glitch_monitor.sv | 97 +++++++++
 tb/tb_hazard_glitch_monitor.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_glitch_monitor_pkg.sv
// Shared types and parameter limits for the hazard glitch monitor.
// Elaboration-time helpers only; no logic.
package hazard_glitch_monitor_pkg;

   typedef enum logic {
      STABLE    = 1'b0,
      EXCURSION = 1'b1
   } state_e;

   localparam int MIN_WIDTH_LO = 2;
   localparam int MIN_WIDTH_HI = 255;

   // The width counter must be able to hold MIN_WIDTH-1 without wrapping.
   function automatic bit min_width_ok(input int min_width, input int width_w);
      return (min_width >= MIN_WIDTH_LO) && (min_width <= MIN_WIDTH_HI) &&
             (width_w < 31) && ((2 ** width_w) > min_width);
   endfunction

endpackage

// File: rtl/hazard_glitch_monitor_sat_counter.sv
// Saturating event counter with synchronous clear and sticky saturation flag.
// Updates one edge after inc/clr; no backpressure, an increment at max only sets sat.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count,
   output logic         sat
);

   localparam logic [W-1:0] MAX = '1;

   logic [W-1:0] count_q, count_d;
   logic         sat_q, sat_d;

   always_comb begin
      count_d = count_q;
      sat_d   = sat_q;
      if (clr) begin
         count_d = '0;
         sat_d   = 1'b0;
      end
      // An event coincident with a clear is counted after the clear.
      if (inc) begin
         if (clr) begin
            count_d = W'(1);
         end else if (count_q == MAX) begin
            sat_d = 1'b1;
         end else begin
            count_d = count_q + W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
         sat_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         sat_q   <= sat_d;
      end
   end

   assign count = count_q;
   assign sat   = sat_q;

endmodule

// File: rtl/hazard_glitch_monitor.sv
// Oversampling deglitcher: short excursions are reported as glitches, long ones toggle stable_out.
// Latency MIN_WIDTH+1 edges for a transition; no backpressure, every event is reported.
module hazard_glitch_monitor
   import hazard_glitch_monitor_pkg::*;
#(
   parameter int MIN_WIDTH = 3,
   parameter int WIDTH_W   = 8,
   parameter int COUNT_W   = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               sig,
   input  logic               clr_count,
   output logic               stable_out,
   output logic               glitch_pulse,
   output logic               glitch_level,
   output logic [WIDTH_W-1:0] last_width,
   output logic [COUNT_W-1:0] glitch_count,
   output logic               count_sat
);

   if (!min_width_ok(MIN_WIDTH, WIDTH_W)) begin : g_bad_params
      $error("hazard_glitch_monitor: MIN_WIDTH out of range or WIDTH_W too narrow");
   end

   localparam logic [WIDTH_W-1:0] W_ACCEPT = WIDTH_W'(MIN_WIDTH - 1);

   state_e             state_q;
   logic               sig_q;
   logic [WIDTH_W-1:0] w_q;
   logic               stable_q;
   logic               pulse_q;
   logic               level_q;
   logic [WIDTH_W-1:0] last_w_q;
   logic               glitch_det;

   assign glitch_det = (state_q == EXCURSION) && (sig_q == stable_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         sig_q    <= 1'b0;
         state_q  <= STABLE;
         w_q      <= '0;
         stable_q <= 1'b0;
         pulse_q  <= 1'b0;
         level_q  <= 1'b0;
         last_w_q <= '0;
      end else begin
         sig_q   <= sig;
         pulse_q <= 1'b0;
         case (state_q)
            STABLE: begin
               if (sig_q != stable_q) begin
                  state_q <= EXCURSION;
                  w_q     <= WIDTH_W'(1);
               end
            end
            EXCURSION: begin
               if (sig_q == stable_q) begin
                  pulse_q  <= 1'b1;
                  level_q  <= stable_q;
                  last_w_q <= w_q;
                  state_q  <= STABLE;
                  w_q      <= '0;
               end else if (w_q == W_ACCEPT) begin
                  stable_q <= ~stable_q;
                  state_q  <= STABLE;
                  w_q      <= '0;
               end else begin
                  w_q <= w_q + WIDTH_W'(1);
               end
            end
            default: begin
               state_q <= STABLE;
               w_q     <= '0;
            end
         endcase
      end
   end

   sat_counter #(
      .W (COUNT_W)
   ) u_count (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr_count),
      .inc   (glitch_det),
      .count (glitch_count),
      .sat   (count_sat)
   );

   assign stable_out   = stable_q;
   assign glitch_pulse = pulse_q;
   assign glitch_level = level_q;
   assign last_width   = last_w_q;

endmodule

// File: tb/tb_hazard_glitch_monitor.sv
// Directed plan items plus random sig/clr/rst traffic, checked against a run-length model.
module tb_hazard_glitch_monitor;

   localparam int MIN_W = 3;
   localparam int WW    = 8;
   localparam int CW    = 2;
   localparam int CMAX  = (1 << CW) - 1;

   logic          clk;
   logic          rst;
   logic          sig;
   logic          clr_count;
   logic          stable_out;
   logic          glitch_pulse;
   logic          glitch_level;
   logic [WW-1:0] last_width;
   logic [CW-1:0] glitch_count;
   logic          count_sat;

   hazard_glitch_monitor #(
      .MIN_WIDTH (MIN_W),
      .WIDTH_W   (WW),
      .COUNT_W   (CW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .sig          (sig),
      .clr_count    (clr_count),
      .stable_out   (stable_out),
      .glitch_pulse (glitch_pulse),
      .glitch_level (glitch_level),
      .last_width   (last_width),
      .glitch_count (glitch_count),
      .count_sat    (count_sat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   // Reference model: raw samples are scanned for runs that differ from the
   // current level; a finished run yields an event visible one edge later.
   int m_stable, m_run;
   int pend_glitch, pend_toggle, pend_width, pend_level;
   int exp_stable, exp_pulse, exp_level, exp_width, exp_count, exp_sat;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_edge(input logic s, input logic r, input logic c);
      if (r) begin
         m_stable = 0; m_run = 0;
         pend_glitch = 0; pend_toggle = 0; pend_width = 0; pend_level = 0;
         exp_stable = 0; exp_pulse = 0; exp_level = 0; exp_width = 0;
         exp_count = 0; exp_sat = 0;
      end else begin
         exp_pulse = pend_glitch;
         if (pend_glitch != 0) begin
            exp_level = pend_level;
            exp_width = pend_width;
         end
         if (pend_toggle != 0) exp_stable = 1 - exp_stable;
         if (c) begin
            exp_count = 0;
            exp_sat   = 0;
         end
         if (pend_glitch != 0) begin
            if (c) exp_count = 1;
            else if (exp_count == CMAX) exp_sat = 1;
            else exp_count = exp_count + 1;
         end
         pend_glitch = 0;
         pend_toggle = 0;
         if (m_run == 0) begin
            if (int'(s) != m_stable) m_run = 1;
         end else if (int'(s) == m_stable) begin
            pend_glitch = 1;
            pend_width  = m_run;
            pend_level  = m_stable;
            m_run       = 0;
         end else begin
            m_run = m_run + 1;
            if (m_run == MIN_W) begin
               pend_toggle = 1;
               m_stable    = 1 - m_stable;
               m_run       = 0;
            end
         end
      end
   endtask

   task automatic check_all();
      if (chk_en) begin
         chk("stable_out",   32'(stable_out),   32'(exp_stable));
         chk("glitch_pulse", 32'(glitch_pulse), 32'(exp_pulse));
         chk("glitch_level", 32'(glitch_level), 32'(exp_level));
         chk("last_width",   32'(last_width),   32'(exp_width));
         chk("glitch_count", 32'(glitch_count), 32'(exp_count));
         chk("count_sat",    32'(count_sat),    32'(exp_sat));
      end
   endtask

   task automatic step(input logic s, input logic r, input logic c);
      sig = s; rst = r; clr_count = c;
      @(posedge clk);
      model_edge(s, r, c);
      @(negedge clk);
      if (r) chk_en = 1'b1;
      check_all();
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_stable"}, 32'(stable_out),   32'd0);
      chk({tag, "_pulse"},  32'(glitch_pulse), 32'd0);
      chk({tag, "_level"},  32'(glitch_level), 32'd0);
      chk({tag, "_width"},  32'(last_width),   32'd0);
      chk({tag, "_count"},  32'(glitch_count), 32'd0);
      chk({tag, "_sat"},    32'(count_sat),    32'd0);
   endtask

   initial begin
      sig = 1'b0; rst = 1'b1; clr_count = 1'b0;

      // 1: reset and quiet input
      step(0, 1, 0);
      step(0, 1, 0);
      check_zero("rst");
      for (int i = 0; i < 10; i++) begin
         step(0, 0, 0);
         chk("quiet_pulse", 32'(glitch_pulse), 32'd0);
      end
      check_zero("quiet");

      // 2: clean rise appears after exactly MIN_W+1 edges
      for (int i = 1; i <= 8; i++) begin
         step(1, 0, 0);
         if (i == MIN_W) chk("rise_early", 32'(stable_out), 32'd0);
         if (i == MIN_W + 1) chk("rise_edge", 32'(stable_out), 32'd1);
      end
      chk("rise_count", 32'(glitch_count), 32'd0);

      // 3: static-1 hazard, single-cycle dip
      step(0, 0, 0);
      step(1, 0, 0);
      step(1, 0, 0);
      chk("dip_pulse", 32'(glitch_pulse), 32'd1);
      chk("dip_level", 32'(glitch_level), 32'd1);
      chk("dip_width", 32'(last_width),   32'd1);
      chk("dip_count", 32'(glitch_count), 32'd1);
      chk("dip_stable", 32'(stable_out),  32'd1);
      step(1, 0, 0);
      chk("dip_pulse_one", 32'(glitch_pulse), 32'd0);

      // 4: boundary widths from level 0
      for (int i = 0; i < 8; i++) step(0, 0, 0);
      step(1, 0, 0); step(1, 0, 0); step(0, 0, 0); step(0, 0, 0);
      chk("blip2_pulse", 32'(glitch_pulse), 32'd1);
      chk("blip2_level", 32'(glitch_level), 32'd0);
      chk("blip2_width", 32'(last_width),   32'd2);
      for (int i = 0; i < 4; i++) step(0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         step(1, 0, 0);
         chk("blip3_nopulse", 32'(glitch_pulse), 32'd0);
      end
      chk("blip3_stable", 32'(stable_out), 32'd1);
      for (int i = 0; i < 4; i++) step(1, 0, 0);

      // 5: saturation with back-to-back dips, then clear coincident with a record
      step(1, 0, 1);
      chk("clr_count", 32'(glitch_count), 32'd0);
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 0);
         step(1, 0, 0);
      end
      step(1, 0, 0);
      step(1, 0, 0);
      chk("sat_count", 32'(glitch_count), 32'd3);
      chk("sat_flag",  32'(count_sat),    32'd1);
      step(0, 0, 0);
      step(1, 0, 0);
      step(1, 0, 1);
      chk("clr_ev_pulse", 32'(glitch_pulse), 32'd1);
      chk("clr_ev_count", 32'(glitch_count), 32'd1);
      chk("clr_ev_sat",   32'(count_sat),    32'd0);
      step(1, 0, 0);

      // 6: reset while an excursion is in progress
      step(0, 0, 0);
      step(0, 0, 0);
      step(0, 1, 0);
      check_zero("midrst");
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 0);
         chk("midrst_pulse", 32'(glitch_pulse), 32'd0);
      end
      for (int i = 0; i < 5; i++) step(1, 0, 0);
      chk("resume_stable", 32'(stable_out), 32'd1);
      step(0, 0, 0); step(1, 0, 0); step(1, 0, 0);
      chk("resume_count", 32'(glitch_count), 32'd1);

      // random runs of 1..5 cycles with occasional clear and reset
      begin
         logic lvl;
         lvl = 1'b1;
         for (int n = 0; n < 250; n++) begin
            int len;
            lvl = ~lvl;
            len = $urandom_range(1, 5);
            for (int k = 0; k < len; k++) begin
               step(lvl, ($urandom_range(0, 199) == 0), ($urandom_range(0, 29) == 0));
            end
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
